// File: rtl/spi_pkg.sv
// Shared types and constants for the byte-oriented SPI target.
package spi_pkg;

    typedef logic [1:0] ss_t;
    typedef logic [7:0] byte_t;

    localparam int SPI_BITS = 8;

endpackage

// File: rtl/spi_bus.sv
// SPI bus shared between one master and up to four targets; miso is a resolved net.
interface SPIbus;

    logic       sck;
    logic       mosi;
    logic [1:0] ss;
    wire        miso;

    modport Master (output sck, output mosi, output ss, input miso);
    modport Slave  (input sck, input mosi, input ss, output miso);

endinterface

// File: rtl/spi_sync.sv
// Single-bit input synchronizer; STAGES=0 passes the input straight through.
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    if (STAGES == 0) begin : g_bypass
        assign q = d;
    end else begin : g_flops
        logic [STAGES-1:0] sr_r;

        // shift the pin value through the synchronizer chain
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sr_r <= {STAGES{RST_VAL}};
            end else begin
                sr_r <= STAGES'({sr_r, d});
            end
        end

        assign q = sr_r[STAGES-1];
    end

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 byte target: oversampled bus, one RX byte per frame, one preloaded TX byte.
module spi_slave
    import spi_pkg::*;
#(
    parameter ss_t   SLAVE_ID    = 2'd0,
    parameter int    SYNC_STAGES = 2,
    parameter byte_t IDLE_BYTE   = 8'hFF
) (
    input  logic       Clk_i,
    input  logic       Rst_ni,
    SPIbus.Slave       Spis,
    input  logic [7:0] Buf_i,
    input  logic       Load_i,
    output logic       Ready_o,
    output logic [7:0] Rcvd_o,
    output logic       Valid_o,
    output logic       Underrun_o
);

    ss_t   ss_s;
    logic  sck_s;
    logic  mosi_s;
    logic  sck_d_r;
    logic  sel_s;
    logic  rise_s;
    logic  fall_s;
    logic  idle_s;
    logic  first_s;
    logic  last_s;
    logic  xfer_s;
    logic  load_ok_s;
    logic  [3:0] bitcnt_r;
    byte_t rx_sr_r;
    byte_t tx_sr_r;
    byte_t hold_r;
    byte_t rcvd_r;
    logic  ready_r;
    logic  loaded_r;
    logic  valid_r;
    logic  underrun_r;

    // ss resets to a code that never selects this instance
    for (genvar i = 0; i < 2; i++) begin : g_ss_sync
        spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(~SLAVE_ID[i])) u_ss_sync (
            .clk   (Clk_i),
            .rst_n (Rst_ni),
            .d     (Spis.ss[i]),
            .q     (ss_s[i])
        );
    end

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
        .clk   (Clk_i),
        .rst_n (Rst_ni),
        .d     (Spis.sck),
        .q     (sck_s)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
        .clk   (Clk_i),
        .rst_n (Rst_ni),
        .d     (Spis.mosi),
        .q     (mosi_s)
    );

    assign sel_s     = (ss_s == SLAVE_ID);
    assign rise_s    = sel_s & sck_s & ~sck_d_r;
    assign fall_s    = sel_s & ~sck_s & sck_d_r;
    assign idle_s    = (bitcnt_r == 4'd0);
    assign first_s   = rise_s & idle_s;
    assign last_s    = rise_s & (bitcnt_r == 4'(SPI_BITS - 1));
    // a byte arriving with the first rise waits for the next frame
    assign xfer_s    = idle_s & ~ready_r & ~first_s;
    assign load_ok_s = Load_i & ready_r;

    // receive path: bit counter, RX shifter and completed-byte register
    always_ff @(posedge Clk_i or negedge Rst_ni) begin
        if (!Rst_ni) begin
            sck_d_r  <= 1'b0;
            bitcnt_r <= 4'd0;
            rx_sr_r  <= 8'h00;
            rcvd_r   <= 8'h00;
            valid_r  <= 1'b0;
        end else begin
            sck_d_r <= sck_s;
            valid_r <= last_s;
            if (!sel_s) begin
                bitcnt_r <= 4'd0;
                rx_sr_r  <= 8'h00;
            end else if (rise_s) begin
                rx_sr_r  <= {rx_sr_r[6:0], mosi_s};
                bitcnt_r <= last_s ? 4'd0 : bitcnt_r + 4'd1;
            end
            if (last_s) begin
                rcvd_r <= {rx_sr_r[6:0], mosi_s};
            end
        end
    end

    // transmit path: holding register, TX shifter and underrun tracking
    always_ff @(posedge Clk_i or negedge Rst_ni) begin
        if (!Rst_ni) begin
            tx_sr_r    <= IDLE_BYTE;
            hold_r     <= 8'h00;
            ready_r    <= 1'b1;
            loaded_r   <= 1'b0;
            underrun_r <= 1'b0;
        end else begin
            if (load_ok_s) begin
                hold_r  <= Buf_i;
                ready_r <= 1'b0;
            end else if (xfer_s) begin
                ready_r <= 1'b1;
            end

            if (first_s && !loaded_r) begin
                tx_sr_r <= IDLE_BYTE;
            end else if (fall_s && !idle_s) begin
                tx_sr_r <= {tx_sr_r[6:0], 1'b0};
            end else if (xfer_s) begin
                tx_sr_r <= hold_r;
            end

            if (xfer_s) begin
                loaded_r <= 1'b1;
            end else if (first_s) begin
                loaded_r <= 1'b0;
            end

            if (first_s && !loaded_r) begin
                underrun_r <= 1'b1;
            end else if (load_ok_s) begin
                underrun_r <= 1'b0;
            end
        end
    end

    assign Spis.miso  = sel_s ? tx_sr_r[7] : 1'bz;
    assign Ready_o    = ready_r;
    assign Rcvd_o     = rcvd_r;
    assign Valid_o    = valid_r;
    assign Underrun_o = underrun_r;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench: a behavioural SPI master (CLKDIV=8) drives four targets, IDs 0..3.
module tb_spi_slave;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       sck   = 1'b0;
    logic       mosi  = 1'b0;
    logic [1:0] ss    = 2'd1;
    logic [3:0] load  = 4'd0;
    logic [7:0] bufv [4];
    logic [7:0] rcvd [4];
    logic [3:0] ready;
    logic [3:0] valid;
    logic [3:0] underrun;
    logic [3:0] mz;
    logic [3:0] mv;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    SPIbus bus[4] ();

    for (genvar g = 0; g < 4; g++) begin : g_dut
        int vcnt = 0;

        assign bus[g].sck  = sck;
        assign bus[g].mosi = mosi;
        assign bus[g].ss   = ss;
        assign mz[g]       = (bus[g].miso === 1'bz);
        assign mv[g]       = bus[g].miso;

        spi_slave #(.SLAVE_ID(2'(g)), .SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) u_dut (
            .Clk_i      (clk),
            .Rst_ni     (rst_n),
            .Spis       (bus[g]),
            .Buf_i      (bufv[g]),
            .Load_i     (load[g]),
            .Ready_o    (ready[g]),
            .Rcvd_o     (rcvd[g]),
            .Valid_o    (valid[g]),
            .Underrun_o (underrun[g])
        );

        always @(posedge clk) begin
            if (valid[g]) vcnt <= vcnt + 1;
        end
    end

    function automatic int vc(input int k);
        case (k)
            0:       return g_dut[0].vcnt;
            1:       return g_dut[1].vcnt;
            2:       return g_dut[2].vcnt;
            default: return g_dut[3].vcnt;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_byte(input int k, input logic [7:0] b);
        bufv[k] = b;
        load[k] = 1'b1;
        @(negedge clk);
        load[k] = 1'b0;
    endtask

    task automatic wait_ready(input int k);
        int n;
        n = 0;
        while (!ready[k] && n < 64) begin
            @(negedge clk);
            n++;
        end
        check_eq("ready_wait", 32'(ready[k]), 32'd1);
    endtask

    // master: miso sampled just before each sck rise, mosi changed on sck fall
    task automatic xfer(input logic [1:0] id, input logic [7:0] tx, input int nbits,
                        output logic [7:0] rx);
        rx   = 8'h00;
        ss   = id;
        mosi = tx[7];
        cyc(4);
        for (int i = 0; i < nbits; i++) begin
            rx  = {rx[6:0], mv[id]};
            sck = 1'b1;
            cyc(4);
            sck = 1'b0;
            if (i < 7) mosi = tx[6-i];
            cyc(4);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [7:0] rx;
        logic [7:0] tx_tab [3];
        logic [7:0] rx_tab [3];
        int         v0, v1, v2, v3;

        tx_tab = '{8'h01, 8'h80, 8'hFF};
        rx_tab = '{8'h11, 8'h22, 8'h33};
        for (int k = 0; k < 4; k++) bufv[k] = 8'h00;

        cyc(4);
        check_eq("rst_ready", 32'(ready), 32'hF);
        check_eq("rst_valid", 32'(valid), 32'h0);
        check_eq("rst_underrun", 32'(underrun), 32'h0);
        check_eq("rst_rcvd0", 32'(rcvd[0]), 32'h00);
        rst_n = 1'b1;
        cyc(4);
        check_eq("desel_z0", 32'(mz[0]), 32'd1);
        check_eq("sel_drive1", 32'(mz[1]), 32'd0);
        check_eq("idle_miso1", 32'(mv[1]), 32'd1);

        // single frame with a preloaded byte
        v0 = vc(0);
        load_byte(0, 8'h3C);
        check_eq("ready_drop", 32'(ready[0]), 32'd0);
        cyc(1);
        check_eq("ready_back", 32'(ready[0]), 32'd1);
        xfer(2'd0, 8'hA5, 8, rx);
        check_eq("m_rx_3c", 32'(rx), 32'h3C);
        check_eq("rcvd_a5", 32'(rcvd[0]), 32'hA5);
        check_eq("valid_once", 32'(vc(0) - v0), 32'd1);
        check_eq("ready_after", 32'(ready[0]), 32'd1);

        // back-to-back frames reloading on each Ready_o
        for (int f = 0; f < 3; f++) begin
            wait_ready(0);
            load_byte(0, tx_tab[f]);
            cyc(2);
            xfer(2'd0, rx_tab[f], 8, rx);
            check_eq("b2b_m_rx", 32'(rx), 32'(tx_tab[f]));
            check_eq("b2b_rcvd", 32'(rcvd[0]), 32'(rx_tab[f]));
        end
        check_eq("b2b_no_underrun", 32'(underrun[0]), 32'd0);

        // frame without a load
        xfer(2'd0, 8'h77, 8, rx);
        check_eq("ur_m_rx_ff", 32'(rx), 32'hFF);
        check_eq("ur_flag", 32'(underrun[0]), 32'd1);
        check_eq("ur_rcvd", 32'(rcvd[0]), 32'h77);
        load_byte(0, 8'h12);
        check_eq("ur_cleared", 32'(underrun[0]), 32'd0);

        // four targets, ID 1 addressed
        load_byte(1, 8'hC3);
        cyc(2);
        v0 = vc(0); v1 = vc(1); v2 = vc(2); v3 = vc(3);
        xfer(2'd1, 8'h96, 8, rx);
        check_eq("id1_m_rx", 32'(rx), 32'hC3);
        check_eq("id1_rcvd", 32'(rcvd[1]), 32'h96);
        check_eq("id1_valid", 32'(vc(1) - v1), 32'd1);
        check_eq("id0_valid", 32'(vc(0) - v0), 32'd0);
        check_eq("id2_valid", 32'(vc(2) - v2), 32'd0);
        check_eq("id3_valid", 32'(vc(3) - v3), 32'd0);
        check_eq("id0_z", 32'(mz[0]), 32'd1);
        check_eq("id2_z", 32'(mz[2]), 32'd1);
        check_eq("id3_z", 32'(mz[3]), 32'd1);
        check_eq("id1_driven", 32'(mz[1]), 32'd0);

        // deselect after 4 bits, then a full frame
        v0 = vc(0);
        xfer(2'd0, 8'hF0, 4, rx);
        ss = 2'd1;
        cyc(6);
        check_eq("part_rcvd_kept", 32'(rcvd[0]), 32'h77);
        check_eq("part_no_valid", 32'(vc(0) - v0), 32'd0);
        load_byte(0, 8'h99);
        cyc(2);
        xfer(2'd0, 8'h5A, 8, rx);
        check_eq("part_m_rx", 32'(rx), 32'h99);
        check_eq("part_rcvd_5a", 32'(rcvd[0]), 32'h5A);
        check_eq("part_valid_one", 32'(vc(0) - v0), 32'd1);

        // reset after 3 bits
        load_byte(0, 8'h44);
        cyc(2);
        v0 = vc(0);
        xfer(2'd0, 8'hAA, 3, rx);
        rst_n = 1'b0;
        #1;
        check_eq("mr_ready", 32'(ready), 32'hF);
        check_eq("mr_valid", 32'(valid), 32'h0);
        check_eq("mr_rcvd0", 32'(rcvd[0]), 32'h00);
        check_eq("mr_underrun", 32'(underrun), 32'h0);
        check_eq("mr_z0", 32'(mz[0]), 32'd1);
        cyc(2);
        rst_n = 1'b1;
        cyc(4);
        load_byte(0, 8'h81);
        cyc(2);
        xfer(2'd0, 8'hE7, 8, rx);
        check_eq("mr_m_rx", 32'(rx), 32'h81);
        check_eq("mr_rcvd_e7", 32'(rcvd[0]), 32'hE7);
        check_eq("mr_valid_one", 32'(vc(0) - v0), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
